// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared constants for the configuration sequencer: ROM layout, device limits
// and FSM state encodings.
package i2c_cfg_sequencer_pkg;

    localparam int CFG_ADDR_W      = 6;
    localparam int CFG_MAX_DEVICES = 3;

    // ROM word holding the number of device blocks that follow.
    localparam logic [CFG_ADDR_W-1:0] COUNT_ADDR = '0;

    typedef logic [3:0] state_t;

    localparam state_t ST_RD_COUNT = 4'd0;
    localparam state_t ST_RD_DEV   = 4'd1;
    localparam state_t ST_RD_SIZE  = 4'd2;
    localparam state_t ST_RD_SUB   = 4'd3;
    localparam state_t ST_RD_DATA  = 4'd4;
    localparam state_t ST_REQ      = 4'd5;
    localparam state_t ST_WAIT     = 4'd6;
    localparam state_t ST_NEXT_DEV = 4'd7;
    localparam state_t ST_DONE     = 4'd8;

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Request/busy handshake and write-record bus between the sequencer and the I2C master.
interface i2c_cfg_sequencer_if;

    logic       i2c_busy;
    logic [7:0] i_addr_w_rw;
    logic [7:0] i_sub_addr;
    logic [7:0] i_data_write;
    logic       req_trans;

    modport master (
        input  i2c_busy,
        output i_addr_w_rw,
        output i_sub_addr,
        output i_data_write,
        output req_trans
    );

    modport slave (
        output i2c_busy,
        input  i_addr_w_rw,
        input  i_sub_addr,
        input  i_data_write,
        input  req_trans
    );

endinterface

// File: rtl/i2c_cfg_sequencer_clk_div.sv
// Free-running divider producing the 50% duty ROM clock and a strobe that is
// high in the clk cycle whose closing edge makes data_clk rise.
module i2c_cfg_sequencer_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic data_clk,
    output logic rise_stb
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             data_clk_reg;
    logic             half_done;

    assign half_done = (cnt_reg == CNT_W'(HALF - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg      <= '0;
            data_clk_reg <= 1'b0;
        end else if (half_done) begin
            cnt_reg      <= '0;
            data_clk_reg <= ~data_clk_reg;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign data_clk = data_clk_reg;
    assign rise_stb = half_done & ~data_clk_reg;

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Boot-time configuration sequencer: walks the configuration ROM and issues one
// I2C register write per (sub-address, data) record through the master handshake.
module i2c_cfg_sequencer
    import i2c_cfg_sequencer_pkg::*;
#(
    parameter int ADDR_W      = CFG_ADDR_W,
    parameter int MAX_DEVICES = CFG_MAX_DEVICES,
    parameter int CLK_DIV     = 4,
    parameter int FETCH_WAIT  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          data,
    output logic                data_clk,
    output logic [ADDR_W-1:0]   rd_address,
    output logic                done,
    i2c_cfg_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(FETCH_WAIT + 1);
    localparam int DEV_W  = $clog2(MAX_DEVICES + 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              addr_end_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [DEV_W-1:0]  dev_total_reg;
    logic [DEV_W-1:0]  dev_done_reg;
    logic [7:0]        cfg_size_reg;
    logic [7:0]        byte_cnt_reg;
    logic [7:0]        addr_w_rw_reg;
    logic [7:0]        sub_addr_reg;
    logic [7:0]        data_write_reg;
    logic              req_reg;
    logic              done_reg;
    logic              rise_stb;
    logic              fetch_state;
    logic              fetch_ready;

    i2c_cfg_sequencer_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_clk (data_clk),
        .rise_stb (rise_stb)
    );

    assign fetch_state = (state_reg == ST_RD_COUNT) || (state_reg == ST_RD_DEV) ||
                         (state_reg == ST_RD_SIZE)  || (state_reg == ST_RD_SUB) ||
                         (state_reg == ST_RD_DATA);
    // Only data_clk edges after the address change are counted, so a ROM with a
    // registered address has settled by the time data is sampled.
    assign fetch_ready = fetch_state && !addr_end_reg && (wait_cnt_reg == WAIT_W'(FETCH_WAIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_RD_COUNT;
            addr_reg       <= ADDR_W'(COUNT_ADDR);
            addr_end_reg   <= 1'b0;
            wait_cnt_reg   <= '0;
            dev_total_reg  <= '0;
            dev_done_reg   <= '0;
            cfg_size_reg   <= '0;
            byte_cnt_reg   <= '0;
            addr_w_rw_reg  <= '0;
            sub_addr_reg   <= '0;
            data_write_reg <= '0;
            req_reg        <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            if (fetch_ready) begin
                wait_cnt_reg <= '0;
                if (addr_reg == '1) begin
                    addr_end_reg <= 1'b1;
                end else begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                end
            end else if (fetch_state && rise_stb) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end

            case (state_reg)
                ST_RD_COUNT: if (fetch_ready) begin
                    if (data == 8'd0 || data > 8'(MAX_DEVICES)) begin
                        state_reg <= ST_DONE;
                    end else begin
                        dev_total_reg <= data[DEV_W-1:0];
                        state_reg     <= ST_RD_DEV;
                    end
                end
                ST_RD_DEV: if (fetch_ready) begin
                    addr_w_rw_reg <= {data[7:1], 1'b0};
                    state_reg     <= ST_RD_SIZE;
                end
                ST_RD_SIZE: if (fetch_ready) begin
                    cfg_size_reg <= data;
                    byte_cnt_reg <= '0;
                    state_reg    <= (data == 8'd0) ? ST_NEXT_DEV : ST_RD_SUB;
                end
                ST_RD_SUB: if (fetch_ready) begin
                    sub_addr_reg <= data;
                    state_reg    <= ST_RD_DATA;
                end
                ST_RD_DATA: if (fetch_ready) begin
                    data_write_reg <= data;
                    state_reg      <= ST_REQ;
                end
                // A master still busy from earlier traffic must go idle before we request.
                ST_REQ: begin
                    if (!req_reg) begin
                        if (!bus.i2c_busy) req_reg <= 1'b1;
                    end else if (bus.i2c_busy) begin
                        req_reg   <= 1'b0;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: if (!bus.i2c_busy) begin
                    byte_cnt_reg <= byte_cnt_reg + 8'd1;
                    state_reg    <= (byte_cnt_reg + 8'd1 == cfg_size_reg) ? ST_NEXT_DEV : ST_RD_SUB;
                end
                ST_NEXT_DEV: begin
                    dev_done_reg <= dev_done_reg + DEV_W'(1);
                    state_reg    <= (dev_done_reg + DEV_W'(1) == dev_total_reg) ? ST_DONE : ST_RD_DEV;
                end
                ST_DONE: begin
                    done_reg <= 1'b1;
                    req_reg  <= 1'b0;
                end
                default: state_reg <= ST_DONE;
            endcase

            // The ROM ends at the top address; a fetch that would run past it ends the walk.
            if (fetch_state && addr_end_reg) state_reg <= ST_DONE;
        end
    end

    assign rd_address       = addr_reg;
    assign done             = done_reg;
    assign bus.req_trans    = req_reg;
    assign bus.i_addr_w_rw  = addr_w_rw_reg;
    assign bus.i_sub_addr   = sub_addr_reg;
    assign bus.i_data_write = data_write_reg;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Self-checking bench: ROM model, I2C master busy model and a record-level
// reference walk of the ROM that predicts the write sequence.
`timescale 1ns/1ps
module tb_i2c_cfg_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data;
    logic       data_clk;
    logic [5:0] rd_address;
    logic       done;

    i2c_cfg_sequencer_if bus();

    i2c_cfg_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data       (data),
        .data_clk   (data_clk),
        .rd_address (rd_address),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ROM with a registered address and a registered output: two data_clk edges of latency.
    logic [7:0] rom [64];
    logic [5:0] rom_addr_q;
    always @(posedge data_clk) begin
        rom_addr_q <= rd_address;
        data       <= rom[rom_addr_q];
    end

    int n_checks = 0;
    int n_fail   = 0;

    bit  busy_auto  = 1'b1;
    bit  busy_force = 1'b0;
    int  busy_delay = 3;
    int  busy_len   = 20;
    logic [23:0] obs_q [$];
    logic [23:0] exp_q [$];
    int  exp_addr;
    int  stab_err;
    int  req_rises;

    // I2C master model: raises busy busy_delay clk after a request, holds it busy_len clk.
    initial begin : busy_model
        int phase;
        int bcnt;
        bit req_prev;
        logic [23:0] cur_tx;
        phase = 0; bcnt = 0; req_prev = 1'b0; cur_tx = '0;
        stab_err = 0; req_rises = 0;
        bus.i2c_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bus.i2c_busy = 1'b0;
                phase = 0; bcnt = 0; req_prev = 1'b0;
                stab_err = 0; req_rises = 0;
                obs_q.delete();
            end else begin
                if (bus.req_trans && !req_prev) req_rises++;
                req_prev = bus.req_trans;
                if (!busy_auto) begin
                    bus.i2c_busy = busy_force;
                end else begin
                    if (phase != 0 &&
                        {bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write} !== cur_tx) stab_err++;
                    case (phase)
                        0: if (bus.req_trans) begin
                            cur_tx = {bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write};
                            obs_q.push_back(cur_tx);
                            phase = 1; bcnt = 0;
                        end
                        1: begin
                            bcnt++;
                            if (bcnt >= busy_delay) begin bus.i2c_busy = 1'b1; phase = 2; bcnt = 0; end
                        end
                        default: begin
                            bcnt++;
                            if (bcnt >= busy_len) begin bus.i2c_busy = 1'b0; phase = 0; end
                        end
                    endcase
                end
            end
        end
    end

    initial begin : watchdog
        #900us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: walk the ROM record by record, stopping where a read would pass address 63.
    task automatic model_expected();
        int pos, d, n;
        bit stop;
        logic [7:0] dev, sub, dt;
        exp_q.delete();
        stop = 1'b0;
        d = int'(rom[0]);
        pos = 1;
        if (d >= 1 && d <= 3) begin
            for (int k = 0; k < d && !stop; k++) begin
                if (pos > 63) begin stop = 1'b1; break; end
                dev = rom[pos] & 8'hFE; pos++;
                if (pos > 63) begin stop = 1'b1; break; end
                n = int'(rom[pos]); pos++;
                for (int j = 0; j < n; j++) begin
                    if (pos > 63) begin stop = 1'b1; break; end
                    sub = rom[pos]; pos++;
                    if (pos > 63) begin stop = 1'b1; break; end
                    dt = rom[pos]; pos++;
                    exp_q.push_back({dev, sub, dt});
                end
            end
        end
        exp_addr = (pos > 63) ? 63 : pos;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_rom(input logic [7:0] bytes [], input bit fill_random);
        for (int i = 0; i < 64; i++) rom[i] = fill_random ? 8'($urandom) : 8'h00;
        for (int i = 0; i < bytes.size(); i++) rom[i] = bytes[i];
    endtask

    task automatic test_sequence(input string name);
        int cyc;
        model_expected();
        apply_reset();
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL %s_done: done=%b required 1 after %0d clk", name, done, cyc);
        end
        for (int i = 0; i < obs_q.size(); i++)
            $display("  %s tx%0d addr=%h sub=%h data=%h", name, i, obs_q[i][23:16], obs_q[i][15:8], obs_q[i][7:0]);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s_tx_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL %s_tx%0d: got %h required %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (rd_address !== 6'(exp_addr)) begin
            n_fail++; $display("FAIL %s_rd_address: got %0d required %0d", name, rd_address, exp_addr);
        end
        n_checks++;
        if (stab_err != 0) begin
            n_fail++; $display("FAIL %s_stable: %0d unstable cycles, required 0", name, stab_err);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bus.req_trans !== 1'b0 || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_sticky: done=%b req=%b tx=%0d required done=1 req=0 tx=%0d",
                     name, done, bus.req_trans, obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic s [8];
        int rises, cyc;
        logic prev;
        load_rom('{8'd1, 8'hB8, 8'd2, 8'h03, 8'h0D, 8'h0A, 8'h55}, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({data_clk, rd_address, bus.req_trans, done, bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: dclk=%b addr=%0d req=%b done=%b a=%h s=%h d=%h required all 0",
                     data_clk, rd_address, bus.req_trans, done, bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin @(negedge clk); s[i] = data_clk; end
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 8; i++) begin if (s[i] && !prev) rises++; prev = s[i]; end
        n_checks++;
        if (rises != 2) begin
            n_fail++; $display("FAIL data_clk_rises: got %0d rises in 8 clk required 2", rises);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (s[i+2] !== ~s[i]) begin
                n_fail++; $display("FAIL data_clk_period_%0d: got %b required %b", i, s[i+2], ~s[i]);
            end
        end
        cyc = 0;
        while (rd_address === 6'd0 && cyc < 40) begin @(negedge clk); cyc++; end
        n_checks++;
        if (rd_address !== 6'd1) begin
            n_fail++; $display("FAIL first_fetch: rd_address=%0d required 1 after fetch of addr 0", rd_address);
        end
    endtask

    task automatic test_single_device();
        busy_auto = 1'b1; busy_delay = 3; busy_len = 20;
        load_rom('{8'd1, 8'hB8, 8'd2, 8'h03, 8'h0D, 8'h0A, 8'h55}, 1'b1);
        test_sequence("single");
    endtask

    task automatic test_two_devices();
        busy_auto = 1'b1; busy_delay = 2; busy_len = 6;
        load_rom('{8'd2, 8'hB9, 8'd1, 8'h01, 8'h11, 8'hBA, 8'd1, 8'h02, 8'h22}, 1'b1);
        test_sequence("two_dev");
    endtask

    task automatic test_empty_block();
        busy_auto = 1'b1; busy_delay = 3; busy_len = 5;
        load_rom('{8'd1, 8'hB8, 8'd0}, 1'b1);
        test_sequence("empty");
        n_checks++;
        if (req_rises != 0) begin
            n_fail++; $display("FAIL empty_req_pulses: got %0d required 0", req_rises);
        end
    endtask

    task automatic test_invalid_count();
        busy_auto = 1'b1; busy_delay = 1; busy_len = 3;
        load_rom('{8'd0, 8'hB8, 8'd1, 8'h01, 8'h02}, 1'b1);
        test_sequence("count0");
        load_rom('{8'd4, 8'hB8, 8'd1, 8'h01, 8'h02}, 1'b1);
        test_sequence("count4");
    endtask

    task automatic test_random();
        int pos, d, n;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
            d = (it == 7) ? 200 : int'($urandom_range(1, 3));
            rom[0] = 8'(d);
            pos = 1;
            for (int k = 0; k < 3; k++) begin
                n = int'($urandom_range(0, 4));
                rom[pos + 1] = 8'(n);
                pos += 2 + 2 * n;
            end
            busy_auto = 1'b1;
            busy_delay = int'($urandom_range(1, 5));
            busy_len = int'($urandom_range(2, 12));
            test_sequence($sformatf("rand%0d", it));
        end
    endtask

    task automatic test_rom_end();
        busy_auto = 1'b1; busy_delay = 1; busy_len = 2;
        load_rom('{8'd1, 8'hB8, 8'd40}, 1'b1);
        test_sequence("rom_end");
    endtask

    task automatic test_busy_hold();
        int cyc, bad;
        logic [23:0] held;
        busy_auto = 1'b0; busy_force = 1'b0;
        load_rom('{8'd1, 8'hB8, 8'd2, 8'h03, 8'h0D, 8'h0A, 8'h55}, 1'b0);
        apply_reset();
        cyc = 0;
        while (bus.req_trans !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
        held = {bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write};
        n_checks++;
        if (bus.req_trans !== 1'b1 || held !== 24'hB8030D) begin
            n_fail++; $display("FAIL hold_first_req: req=%b rec=%h required req=1 rec=b8030d", bus.req_trans, held);
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.req_trans !== 1'b1 || {bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write} !== held) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL hold_stable: %0d cycles dropped req or changed record, required 0", bad);
        end
        busy_force = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.req_trans !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: req=%b after busy seen, required 0", bus.req_trans);
        end
    endtask

    task automatic test_busy_at_request();
        int cyc;
        busy_auto = 1'b0; busy_force = 1'b1;
        load_rom('{8'd1, 8'hB8, 8'd1, 8'h03, 8'h0D}, 1'b0);
        apply_reset();
        repeat (150) @(negedge clk);
        n_checks++;
        if (req_rises != 0 || bus.req_trans !== 1'b0 || bus.i_data_write !== 8'h0D) begin
            n_fail++;
            $display("FAIL busy_first_req: rises=%0d req=%b data=%h required 0,0,0d", req_rises, bus.req_trans, bus.i_data_write);
        end
        busy_force = 1'b0;
        cyc = 0;
        while (bus.req_trans !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        n_checks++;
        if (bus.req_trans !== 1'b1) begin
            n_fail++; $display("FAIL busy_then_req: req=%b 10 clk after busy fell, required 1", bus.req_trans);
        end
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        busy_auto = 1'b1; busy_delay = 3; busy_len = 40;
        load_rom('{8'd2, 8'hB8, 8'd1, 8'h01, 8'h11, 8'hBA, 8'd1, 8'h02, 8'h22}, 1'b1);
        model_expected();
        apply_reset();
        cyc = 0;
        while (!(bus.i2c_busy === 1'b1 && bus.req_trans === 1'b0) && cyc < 500) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({data_clk, rd_address, bus.req_trans, done, bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write} !== '0) begin
            n_fail++;
            $display("FAIL midwait_reset: dclk=%b addr=%0d req=%b done=%b a=%h s=%h d=%h required all 0",
                     data_clk, rd_address, bus.req_trans, done, bus.i_addr_w_rw, bus.i_sub_addr, bus.i_data_write);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rd_address !== 6'd0) begin
            n_fail++; $display("FAIL midwait_restart_addr: got %0d required 0", rd_address);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin @(negedge clk); cyc++; end
        n_checks++;
        if (done !== 1'b1 || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL midwait_rerun: done=%b tx=%0d required done=1 tx=%0d", done, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            $display("  midwait tx%0d addr=%h sub=%h data=%h", i, obs_q[i][23:16], obs_q[i][15:8], obs_q[i][7:0]);
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midwait_tx%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin : main
        test_reset();
        test_single_device();
        test_two_devices();
        test_empty_block();
        test_invalid_count();
        test_busy_hold();
        test_busy_at_request();
        test_reset_mid_wait();
        test_random();
        test_rom_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Boot-time configuration sequencer for the TVP5147M1 decoder interface.
- Walks a byte-wide, 64-entry configuration ROM (the rom_1 macro, external to this block) and turns each (sub-address, data) record into one I2C register write.
- Each write is handed to the i2c_master_controller (external) through a request/busy handshake.
- Raises done once every device block in the ROM has been written.

Parameters:
- ADDR_W, 6, ROM address width; 64 entries.
- MAX_DEVICES, 3, maximum device blocks; the device counter is 2 bits.
- CLK_DIV, 4, clk cycles per data_clk period; must be even and ≥ 2.
- FETCH_WAIT, 2, data_clk rising edges between an rd_address change and sampling data.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i2c_busy  in  1  I2C master busy flag.
- data  in  8  ROM read data (ROM q).
- data_clk  out  1  ROM clock; clk divided by CLK_DIV, 50% duty.
- rd_address  out  6  ROM address.
- i_addr_w_rw  out  8  7-bit device address in [7:1], R/W in [0]; always driven 0 in [0] (write).
- i_sub_addr  out  8  register sub-address.
- i_data_write  out  8  register data.
- req_trans  out  1  transaction request.
- done  out  1  configuration complete, sticky.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). All state changes on rising clk.
- Reset values: all outputs 0. This includes data_clk, rd_address, req_trans and done. Divider counter, device counter, byte counter and cfg_size are also cleared.
- ROM layout:
  - addr 0: device count D, valid range 1..MAX_DEVICES.
  - Per device block, in order: device write address (bit0 forced 0 on output), cfg_size n, then n pairs of (sub_addr, data).
- Fetch rule: after rd_address changes, data is sampled only after FETCH_WAIT rising data_clk edges. This covers a ROM with a registered address input.
- FSM states:
  - RD_COUNT: fetch addr 0 into D. If D == 0 or D > MAX_DEVICES → DONE.
  - RD_DEV: fetch the device address; latch it into i_addr_w_rw with [0] = 0.
  - RD_SIZE: fetch n into cfg_size; clear byte_cnt. If n == 0 → NEXT_DEV.
  - RD_SUB: fetch the sub-address into i_sub_addr.
  - RD_DATA: fetch the data byte into i_data_write.
  - REQ: hold req_trans = 1 until i2c_busy is sampled 1, then req_trans = 0 → WAIT.
  - WAIT: stay until i2c_busy is sampled 0; byte_cnt += 1. If byte_cnt == cfg_size → NEXT_DEV, else → RD_SUB.
  - NEXT_DEV: inited_devices += 1. If inited_devices == D → DONE, else → RD_DEV.
  - DONE: done = 1, req_trans = 0; stay until reset.
- rd_address increments by 1 after every fetch.
- Wrap-around: if a fetch would need an address beyond 63, go to DONE; the address never wraps.
- i_addr_w_rw, i_sub_addr and i_data_write are stable from the cycle req_trans rises until i2c_busy falls.
- Busy at request time: if i2c_busy is already 1 when REQ is entered, REQ waits for busy to fall first, then requests.
- The data_clk divider runs free from reset, independent of FSM state.
- Reset mid-transaction: everything returns to reset values immediately and the sequence restarts from addr 0 on release. The I2C master is reset by the same reset_n.

Decomposition:
- Shared package (cfg_pkg): FSM state enum, ROM layout offsets (COUNT_ADDR = 0), ADDR_W, MAX_DEVICES.
- One natural sub-module: cfg_clk_div, producing data_clk and a data_clk rising-edge strobe for fetch counting.

Test Plan:
- Reset: hold reset_n = 0 → all outputs 0. Release → data_clk toggles every 2 clk; first fetch is at rd_address 0.
- Single device: ROM {1, 0xB8, 2, 0x03, 0x0D, 0x0A, 0x55}; busy model raises busy 3 clk after req and holds it 20 clk.
  - Required: two transactions, (0xB8, 0x03, 0x0D) then (0xB8, 0x0A, 0x55).
  - Then done = 1 with rd_address = 7.
- Two devices: ROM {2, 0xB8, 1, 0x01, 0x11, 0xBA, 1, 0x02, 0x22}.
  - Required: writes (0xB8, 0x01, 0x11) then (0xBA, 0x02, 0x22), then done.
  - A device byte 0xB9 is output as 0xB8.
- Empty block: ROM {1, 0xB8, 0} → no req_trans pulse, done = 1.
- Invalid count: ROM[0] = 0 → done immediately. ROM[0] = 4 → done, no transactions.
- Handshake and reset:
  - Busy stays 0 for 50 clk after req → req_trans stays high and outputs stay stable.
  - Asserting reset_n = 0 mid-WAIT clears all outputs; after release the sequence restarts from addr 0.
